seq_game_core: RTL and testbench

SEQ_GAME_CORE -- requirements
Module: seq_game_core

---
 rtl/seq_game_core.sv | 238 +++++++++++++++++++++++
 tb/tb_seq_game_core.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_game_core.sv
// seq_game_core -- memory-sequence ("Simon") game engine.
// Each round an LFSR appends one random symbol to the sequence memory. The
// sequence is replayed on the lamps at tick pace, and then the player repeats it
// forward or in reverse. Lamp and status outputs are registered. They are
// computed from the next state, so they line up with the state register.
module seq_game_core #(
    parameter  int unsigned N_CH          = 4,
    parameter  int unsigned MAX_LEN       = 16,
    parameter  int unsigned TIMEOUT_TICKS = 10,
    localparam int unsigned LW            = $clog2(MAX_LEN + 1),
    localparam int unsigned PW            = $clog2(MAX_LEN * (MAX_LEN + 1) / 2 + 1)
) (
    input  logic            CLOCK_50,
    input  logic            reset_n,
    input  logic            tick,
    input  logic            start,
    input  logic            mode,
    input  logic [15:0]     seed,
    input  logic [LW-1:0]   target_len,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] leds,
    output logic [LW-1:0]   round,
    output logic [PW-1:0]   points,
    output logic            busy,
    output logic            win,
    output logic            lose
);

    localparam int unsigned SW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH = 1 << IW;
    localparam int unsigned TW    = 8;
    localparam logic [15:0] ZERO_SEED_SUB = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_PLAY_ON,
        S_PLAY_OFF,
        S_WAIT_IN,
        S_WIN,
        S_LOSE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [LW-1:0]   target_q, target_d;
    logic            mode_q, mode_d;
    logic [LW-1:0]   round_q, round_d;
    logic [PW-1:0]   points_q, points_d;
    logic [IW-1:0]   play_idx_q, play_idx_d;
    logic [IW-1:0]   entry_idx_q, entry_idx_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [SW-1:0]   mem_q [DEPTH];
    logic [SW-1:0]   mem_d [DEPTH];
    logic [N_CH-1:0] leds_q, leds_d;
    logic            busy_q, busy_d;
    logic            win_q, win_d;
    logic            lose_q, lose_d;

    logic            lfsr_fb;
    logic [SW-1:0]   new_sym;
    logic [LW-1:0]   target_clamped;
    logic [LW-1:0]   last_idx;
    logic [N_CH-1:0] exp_onehot;
    logic            press_ok;
    logic            last_elem;

    // The Fibonacci LFSR shifts right. Taps 16,14,13,11 map to bits 0,2,3,5.
    // Feedback enters at bit 15.
    assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign new_sym    = SW'({24'd0, lfsr_q[7:0]} % N_CH);
    assign last_idx   = round_q - LW'(1);
    assign exp_onehot = {{(N_CH-1){1'b0}}, 1'b1} << mem_q[entry_idx_q];
    assign press_ok   = (btn == exp_onehot);
    assign last_elem  = mode_q ? (entry_idx_q == '0) : (LW'(entry_idx_q) == last_idx);

    // Clamp the requested winning length to 1..MAX_LEN.
    always_comb begin
        target_clamped = target_len;
        if (target_len == '0) begin
            target_clamped = LW'(1);
        end else if (32'(target_len) > MAX_LEN) begin
            target_clamped = LW'(MAX_LEN);
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            lfsr_q      <= '0;
            target_q    <= '0;
            mode_q      <= 1'b0;
            round_q     <= '0;
            points_q    <= '0;
            play_idx_q  <= '0;
            entry_idx_q <= '0;
            to_cnt_q    <= '0;
            leds_q      <= '0;
            busy_q      <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            lfsr_q      <= lfsr_d;
            target_q    <= target_d;
            mode_q      <= mode_d;
            round_q     <= round_d;
            points_q    <= points_d;
            play_idx_q  <= play_idx_d;
            entry_idx_q <= entry_idx_d;
            to_cnt_q    <= to_cnt_d;
            leds_q      <= leds_d;
            busy_q      <= busy_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            mem_q       <= mem_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        target_d    = target_q;
        mode_d      = mode_q;
        round_d     = round_q;
        points_d    = points_q;
        play_idx_d  = play_idx_q;
        entry_idx_d = entry_idx_q;
        to_cnt_d    = to_cnt_q;
        mem_d       = mem_q;
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    lfsr_d   = (seed == '0) ? ZERO_SEED_SUB : seed;
                    target_d = target_clamped;
                    mode_d   = mode;
                    round_d  = '0;
                    points_d = '0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                mem_d[round_q[IW-1:0]] = new_sym;
                lfsr_d     = {lfsr_fb, lfsr_q[15:1]};
                round_d    = round_q + LW'(1);
                play_idx_d = '0;
                state_d    = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (tick) begin
                    state_d = S_PLAY_OFF;
                end
            end
            S_PLAY_OFF: begin
                if (tick) begin
                    if (LW'(play_idx_q) == last_idx) begin
                        entry_idx_d = mode_q ? IW'(last_idx) : '0;
                        to_cnt_d    = '0;
                        state_d     = S_WAIT_IN;
                    end else begin
                        play_idx_d = play_idx_q + IW'(1);
                        state_d    = S_PLAY_ON;
                    end
                end
            end
            S_WAIT_IN: begin
                // A press outranks a coincident tick, so that tick is not counted.
                if (btn != '0) begin
                    if (press_ok) begin
                        to_cnt_d    = '0;
                        entry_idx_d = mode_q ? (entry_idx_q - IW'(1)) : (entry_idx_q + IW'(1));
                        if (last_elem) begin
                            points_d = points_q + PW'(round_q);
                            state_d  = (round_q == target_q) ? S_WIN : S_ADD;
                        end
                    end else begin
                        state_d = S_LOSE;
                    end
                end else if (tick) begin
                    to_cnt_d = to_cnt_q + TW'(1);
                    if (to_cnt_q + TW'(1) == TW'(TIMEOUT_TICKS)) begin
                        state_d = S_LOSE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are derived from the next state.
    // PLAY_ON reads mem_d so that a symbol written in ADD shows immediately.
    always_comb begin
        leds_d = '0;
        busy_d = 1'b0;
        win_d  = 1'b0;
        lose_d = 1'b0;
        case (state_d)
            S_ADD, S_PLAY_OFF: busy_d = 1'b1;
            S_PLAY_ON: begin
                busy_d = 1'b1;
                leds_d = {{(N_CH-1){1'b0}}, 1'b1} << mem_d[play_idx_d];
            end
            S_WAIT_IN: begin
                busy_d = 1'b1;
                if (state_q == S_WAIT_IN) begin
                    leds_d = btn;
                end
            end
            S_WIN: begin
                leds_d = '1;
                win_d  = 1'b1;
            end
            S_LOSE:  lose_d = 1'b1;
            default: leds_d = '0;
        endcase
    end

    assign leds   = leds_q;
    assign round  = round_q;
    assign points = points_q;
    assign busy   = busy_q;
    assign win    = win_q;
    assign lose   = lose_q;

endmodule

// File: tb/tb_seq_game_core.sv
// tb_seq_game_core -- randomized scenario bench for seq_game_core.
// The reference model derives the symbol sequence from the LFSR rule and
// tracks round and score arithmetically.
module tb_seq_game_core;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TMO     = 10;
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);
    localparam int unsigned PW      = $clog2(MAX_LEN * (MAX_LEN + 1) / 2 + 1);
    localparam int unsigned OW      = 3 + N_CH + LW + PW;

    logic            clk = 1'b0;
    logic            reset_n, tick, start, mode;
    logic [15:0]     seed;
    logic [LW-1:0]   target_len;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] leds;
    logic [LW-1:0]   round;
    logic [PW-1:0]   points;
    logic            busy, win, lose;
    logic [OW-1:0]   obs;

    int checks = 0;
    int errors = 0;
    int ref_seq[32];
    int pts;

    seq_game_core #(.N_CH(N_CH), .MAX_LEN(MAX_LEN), .TIMEOUT_TICKS(TMO)) dut (
        .CLOCK_50(clk), .reset_n(reset_n), .tick(tick), .start(start), .mode(mode),
        .seed(seed), .target_len(target_len), .btn(btn), .leds(leds), .round(round),
        .points(points), .busy(busy), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    assign obs = {busy, win, lose, leds, round, points};

    // Expected observation vector: {busy, win, lose, leds, round, points}.
    function automatic logic [OW-1:0] ev(input bit b, input bit w, input bit l,
                                         input logic [N_CH-1:0] ld, input int r, input int p);
        return {b, w, l, ld, LW'(r), PW'(p)};
    endfunction

    function automatic logic [N_CH-1:0] oh(input int s);
        logic [N_CH-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // Symbol k is the low byte of the k-th LFSR state, modulo N_CH.
    function automatic void gen_seq(input int unsigned s);
        int unsigned st, fb;
        st = s;
        for (int i = 0; i < 32; i++) begin
            ref_seq[i] = int'((st & 255) % N_CH);
            fb = (st ^ (st >> 2) ^ (st >> 3) ^ (st >> 5)) & 1;
            st = ((st >> 1) | (fb << 15)) & 16'hFFFF;
        end
    endfunction

    function automatic logic [15:0] rand_seed();
        return 16'($urandom_range(1, 65535));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input logic [15:0] sd, input int tl, input bit md);
        logic [OW-1:0] e;
        seed = sd; target_len = LW'(tl); mode = md; start = 1'b1;
        step();
        start = 1'b0;
        pts = 0;
        // Inputs are latched only on start, so scramble them afterwards.
        seed = 16'($urandom); target_len = LW'($urandom); mode = 1'($urandom);
        e = ev(1, 0, 0, '0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL start got=%h exp=%h", obs, e); end
    endtask

    // Called while in ADD; steps through the playback of round r and ends in WAIT_IN.
    task automatic playback(input int r);
        logic [OW-1:0] e;
        int gaps;
        step();
        for (int i = 0; i < r; i++) begin
            e = ev(1, 0, 0, oh(ref_seq[i]), r, pts); checks++;
            if (obs !== e) begin errors++; $display("FAIL play_on r=%0d i=%0d got=%h exp=%h", r, i, obs, e); end
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) step();
            e = ev(1, 0, 0, oh(ref_seq[i]), r, pts); checks++;
            if (obs !== e) begin errors++; $display("FAIL play_hold r=%0d i=%0d got=%h exp=%h", r, i, obs, e); end
            tick = 1'b1; step(); tick = 1'b0;
            e = ev(1, 0, 0, '0, r, pts); checks++;
            if (obs !== e) begin errors++; $display("FAIL play_off r=%0d i=%0d got=%h exp=%h", r, i, obs, e); end
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) step();
            tick = 1'b1; step(); tick = 1'b0;
        end
    endtask

    // Enters all r elements correctly, with a few ticks before each press.
    task automatic enter(input int r, input bit md);
        logic [OW-1:0] e;
        int idx, nt;
        for (int k = 0; k < r; k++) begin
            idx = md ? (r - 1 - k) : k;
            nt  = int'($urandom_range(0, 3));
            for (int t = 0; t < nt; t++) begin
                tick = 1'b1; step(); tick = 1'b0;
            end
            btn = oh(ref_seq[idx]); step(); btn = '0;
            if (k < r - 1) begin
                e = ev(1, 0, 0, oh(ref_seq[idx]), r, pts); checks++;
                if (obs !== e) begin errors++; $display("FAIL echo r=%0d k=%0d got=%h exp=%h", r, k, obs, e); end
            end
        end
        pts += r;
    endtask

    task automatic play_round(input int r, input bit md, input int tl_eff);
        logic [OW-1:0] e;
        playback(r);
        enter(r, md);
        if (r == tl_eff) e = ev(0, 1, 0, '1, r, pts);
        else             e = ev(1, 0, 0, '0, r, pts);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL round_end r=%0d got=%h exp=%h", r, obs, e); end
    endtask

    task automatic test_reset();
        logic [OW-1:0] e;
        reset_n = 1'b0; tick = 1'b0; start = 1'b0; mode = 1'b0;
        seed = '0; target_len = '0; btn = '0;
        step(); step();
        e = ev(0, 0, 0, '0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset got=%h exp=%h", obs, e); end
        reset_n = 1'b1;
        tick = 1'b1; btn = 4'b0100; step(); tick = 1'b0; btn = '0;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_forward_win();
        logic [OW-1:0] e;
        logic [15:0] sd;
        sd = rand_seed(); gen_seq(sd);
        start_game(sd, 3, 0);
        play_round(1, 0, 3);
        playback(2);
        // A start request mid-game must be ignored, including its target_len.
        start = 1'b1; target_len = LW'(1); step(); start = 1'b0;
        e = ev(1, 0, 0, '0, 2, 1); checks++;
        if (obs !== e) begin errors++; $display("FAIL start_ignored got=%h exp=%h", obs, e); end
        enter(2, 0);
        e = ev(1, 0, 0, '0, 2, 3); checks++;
        if (obs !== e) begin errors++; $display("FAIL fwd_r2 got=%h exp=%h", obs, e); end
        play_round(3, 0, 3);
        e = ev(0, 1, 0, 4'b1111, 3, 6); checks++;
        if (obs !== e) begin errors++; $display("FAIL fwd_win got=%h exp=%h", obs, e); end
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; btn = N_CH'($urandom); step();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL win_hold got=%h exp=%h", obs, e); end
        end
        tick = 1'b0; btn = '0;
    endtask

    task automatic test_wrong_press();
        logic [OW-1:0] e;
        logic [15:0] sd;
        sd = rand_seed(); gen_seq(sd);
        start_game(sd, 5, 0);
        play_round(1, 0, 5);
        playback(2);
        btn = oh((ref_seq[0] + int'($urandom_range(1, 3))) % N_CH); step(); btn = '0;
        e = ev(0, 0, 1, '0, 2, 1); checks++;
        if (obs !== e) begin errors++; $display("FAIL wrong_press got=%h exp=%h", obs, e); end
        tick = 1'b1; step(); tick = 1'b0;
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lose_hold got=%h exp=%h", obs, e); end
    endtask

    task automatic test_timeout();
        logic [OW-1:0] e;
        logic [15:0] sd;
        sd = rand_seed(); gen_seq(sd);
        start_game(sd, 2, 0);
        playback(1);
        for (int t = 1; t < TMO; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
            if ($urandom_range(0, 1) == 1) step();
            e = ev(1, 0, 0, '0, 1, 0); checks++;
            if (obs !== e) begin errors++; $display("FAIL timeout_early t=%0d got=%h exp=%h", t, obs, e); end
        end
        tick = 1'b1; step(); tick = 1'b0;
        e = ev(0, 0, 1, '0, 1, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL timeout_lose got=%h exp=%h", obs, e); end
        // A press coincident with the last allowed tick wins over the timeout.
        start_game(sd, 2, 0);
        playback(1);
        for (int t = 1; t < TMO; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        tick = 1'b1; btn = oh(ref_seq[0]); step(); tick = 1'b0; btn = '0;
        pts = 1;
        e = ev(1, 0, 0, '0, 1, 1); checks++;
        if (obs !== e) begin errors++; $display("FAIL press_beats_tick got=%h exp=%h", obs, e); end
        playback(2);
        for (int t = 1; t < TMO; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        tick = 1'b1; btn = oh(ref_seq[0]); step(); tick = 1'b0; btn = '0;
        e = ev(1, 0, 0, oh(ref_seq[0]), 2, 1); checks++;
        if (obs !== e) begin errors++; $display("FAIL press_tick_echo got=%h exp=%h", obs, e); end
        for (int t = 1; t < TMO; t++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        e = ev(1, 0, 0, '0, 2, 1); checks++;
        if (obs !== e) begin errors++; $display("FAIL timeout_cleared got=%h exp=%h", obs, e); end
        btn = oh(ref_seq[1]); step(); btn = '0;
        e = ev(0, 1, 0, '1, 2, 3); checks++;
        if (obs !== e) begin errors++; $display("FAIL timeout_win got=%h exp=%h", obs, e); end
    endtask

    task automatic test_reverse();
        logic [OW-1:0] e;
        logic [15:0] sd;
        sd = rand_seed(); gen_seq(sd);
        start_game(sd, 2, 1);
        play_round(1, 1, 2);
        play_round(2, 1, 2);
        e = ev(0, 1, 0, '1, 2, 3); checks++;
        if (obs !== e) begin errors++; $display("FAIL reverse_win got=%h exp=%h", obs, e); end
        for (int k = 0; k < 200; k++) begin
            sd = rand_seed(); gen_seq(sd);
            if (ref_seq[0] != ref_seq[1]) break;
        end
        start_game(sd, 2, 1);
        play_round(1, 1, 2);
        playback(2);
        btn = oh(ref_seq[0]); step(); btn = '0;
        if (ref_seq[0] != ref_seq[1]) e = ev(0, 0, 1, '0, 2, 1);
        else                          e = ev(1, 0, 0, oh(ref_seq[0]), 2, 1);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reverse_fwd_order got=%h exp=%h", obs, e); end
    endtask

    task automatic test_boundaries();
        logic [OW-1:0] e;
        logic [15:0] sd;
        bit md;
        sd = rand_seed(); gen_seq(sd);
        start_game(sd, 0, 0);
        play_round(1, 0, 1);
        e = ev(0, 1, 0, '1, 1, 1); checks++;
        if (obs !== e) begin errors++; $display("FAIL tlen_zero got=%h exp=%h", obs, e); end
        sd = rand_seed(); gen_seq(sd); md = 1'($urandom);
        start_game(sd, MAX_LEN + 5, md);
        for (int r = 1; r <= MAX_LEN; r++) play_round(r, md, MAX_LEN);
        e = ev(0, 1, 0, '1, MAX_LEN, MAX_LEN * (MAX_LEN + 1) / 2); checks++;
        if (obs !== e) begin errors++; $display("FAIL tlen_max got=%h exp=%h", obs, e); end
        gen_seq(16'hACE1);
        start_game(16'h0000, 3, 0);
        for (int r = 1; r <= 3; r++) play_round(r, 0, 3);
        e = ev(0, 1, 0, '1, 3, 6); checks++;
        if (obs !== e) begin errors++; $display("FAIL zero_seed got=%h exp=%h", obs, e); end
        sd = rand_seed(); gen_seq(sd);
        start_game(sd, 3, 0);
        playback(1);
        btn = 4'b0011; step(); btn = '0;
        e = ev(0, 0, 1, '0, 1, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL two_hot got=%h exp=%h", obs, e); end
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] e;
        logic [15:0] sd;
        sd = rand_seed(); gen_seq(sd);
        start_game(sd, 8, 0);
        for (int r = 1; r <= 3; r++) play_round(r, 0, 8);
        step();
        e = ev(1, 0, 0, oh(ref_seq[0]), 4, 6); checks++;
        if (obs !== e) begin errors++; $display("FAIL play_on_r4 got=%h exp=%h", obs, e); end
        reset_n = 1'b0; start = 1'b1; tick = 1'b1; step();
        start = 1'b0; tick = 1'b0;
        e = ev(0, 0, 0, '0, 0, 0); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_mid got=%h exp=%h", obs, e); end
        reset_n = 1'b1; step();
        start_game(sd, 8, 0);
        playback(1);
        enter(1, 0);
        e = ev(1, 0, 0, '0, 1, 1); checks++;
        if (obs !== e) begin errors++; $display("FAIL replay_r1 got=%h exp=%h", obs, e); end
        reset_n = 1'b0; step(); reset_n = 1'b1; step();
    endtask

    initial begin
        test_reset();
        test_forward_win();
        test_wrong_press();
        test_timeout();
        test_reverse();
        test_boundaries();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
